mtrx_serializer: RTL

MTRX_SERIALIZER -- requirements
Module: mtrx_serializer

---
 rtl/mtrx_pkg.sv | 12 +
 rtl/mtrx_index_counter.sv | 68 ++++++
 rtl/mtrx_serializer.sv | 106 ++++++++++
 3 files changed

// File: rtl/mtrx_pkg.sv
// Shared constants and state type for the matrix datapath blocks.
package mtrx_pkg;
  localparam int ELEM_W = 8;
  localparam int DIM    = 5;
  localparam int MTRX_W = DIM * DIM * ELEM_W;
  localparam int IDX_W  = 5;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } mtrx_state_e;
endpackage

// File: rtl/mtrx_index_counter.sv
// Row/column sequence counter; reports the linear index and last flag of the next position.
// Emission order is column-major when MTRX_TRANSPOSE_EN is defined, row-major otherwise.
module mtrx_index_counter #(
  parameter int DIM = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       advance,
  output logic [4:0] next_index,
  output logic       next_last
);
  import mtrx_pkg::*;

  localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [CW-1:0] LAST_POS = CW'(DIM - 1);

  logic [CW-1:0] row_r;
  logic [CW-1:0] col_r;
  logic [CW-1:0] row_nx_s;
  logic [CW-1:0] col_nx_s;

  // Next position: the inner counter wraps and carries into the outer one.
  always_comb begin
    row_nx_s = row_r;
    col_nx_s = col_r;
`ifdef MTRX_TRANSPOSE_EN
    if (row_r == LAST_POS) begin
      row_nx_s = {CW{1'b0}};
      if (col_r == LAST_POS) begin
        col_nx_s = {CW{1'b0}};
      end else begin
        col_nx_s = col_r + CW'(1);
      end
    end else begin
      row_nx_s = row_r + CW'(1);
    end
`else
    if (col_r == LAST_POS) begin
      col_nx_s = {CW{1'b0}};
      if (row_r == LAST_POS) begin
        row_nx_s = {CW{1'b0}};
      end else begin
        row_nx_s = row_r + CW'(1);
      end
    end else begin
      col_nx_s = col_r + CW'(1);
    end
`endif
  end

  assign next_index = IDX_W'(row_nx_s) * IDX_W'(DIM) + IDX_W'(col_nx_s);
  assign next_last  = (row_nx_s == LAST_POS) && (col_nx_s == LAST_POS);

  // Position register; restart wins over advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r <= {CW{1'b0}};
      col_r <= {CW{1'b0}};
    end else if (restart) begin
      row_r <= {CW{1'b0}};
      col_r <= {CW{1'b0}};
    end else if (advance) begin
      row_r <= row_nx_s;
      col_r <= col_nx_s;
    end
  end
endmodule

// File: rtl/mtrx_serializer.sv
// Captures a packed DIM x DIM matrix and streams its elements over a valid/ready port.
// Define MTRX_TRANSPOSE_EN for column-major emission order.
module mtrx_serializer #(
  parameter int ELEM_W = mtrx_pkg::ELEM_W,
  parameter int DIM    = mtrx_pkg::DIM
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_valid,
  input  logic [DIM*DIM*ELEM_W-1:0] load_data,
  output logic                      load_ready,
  input  logic                      clear,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ELEM_W-1:0]         out_data,
  output logic [4:0]                out_index,
  output logic                      out_last,
  output logic                      busy
);
  import mtrx_pkg::*;

  localparam int HOLD_W = DIM * DIM * ELEM_W;

  mtrx_state_e       state_r;
  logic [HOLD_W-1:0] hold_r;
  logic [4:0]        next_index_s;
  logic              next_last_s;
  logic              restart_s;
  logic              advance_s;

  assign restart_s = clear || (state_r == ST_IDLE);
  assign advance_s = (state_r == ST_STREAM) && out_ready;

  mtrx_index_counter #(.DIM(DIM)) u_index_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart_s),
    .advance    (advance_s),
    .next_index (next_index_s),
    .next_last  (next_last_s)
  );

  // Serializer FSM; every output is registered so out_ready never reaches them combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      hold_r     <= {HOLD_W{1'b0}};
      load_ready <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= {ELEM_W{1'b0}};
      out_index  <= 5'd0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
    end else if (clear) begin
      state_r    <= ST_IDLE;
      hold_r     <= {HOLD_W{1'b0}};
      load_ready <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= {ELEM_W{1'b0}};
      out_index  <= 5'd0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load_valid) begin
            state_r    <= ST_STREAM;
            hold_r     <= load_data;
            load_ready <= 1'b0;
            out_valid  <= 1'b1;
            out_data   <= load_data[ELEM_W-1:0];
            out_index  <= 5'd0;
            out_last   <= (DIM * DIM == 1);
            busy       <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (out_ready) begin
            if (out_last) begin
              state_r    <= ST_IDLE;
              load_ready <= 1'b1;
              out_valid  <= 1'b0;
              out_data   <= {ELEM_W{1'b0}};
              out_index  <= 5'd0;
              out_last   <= 1'b0;
              busy       <= 1'b0;
            end else begin
              out_data  <= hold_r[int'(next_index_s) * ELEM_W +: ELEM_W];
              out_index <= next_index_s;
              out_last  <= next_last_s;
            end
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          load_ready <= 1'b1;
          out_valid  <= 1'b0;
          out_data   <= {ELEM_W{1'b0}};
          out_index  <= 5'd0;
          out_last   <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end
endmodule
